// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial two's-complement adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its MSB
// so the top level can derive signed overflow on the final digit.
module addsub_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   output logic [DIGIT-1:0] s_d,
   output logic             cout_d,
   output logic             c_msb
);

   logic [DIGIT:0] w_carry;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s_d[i]       = a_d[i] ^ b_d[i] ^ w_carry[i];
      assign w_carry[i+1] = (a_d[i] & b_d[i]) | (w_carry[i] & (a_d[i] ^ b_d[i]));
   end

   assign cout_d = w_carry[DIGIT];
   assign c_msb  = w_carry[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract, DIGIT bits per clock LSB first, behind valid/ready
// handshakes on both the operand and result side.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be >= 1 and a multiple of DIGIT");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_outValid;

   logic [DIGIT-1:0] w_sd;
   logic             w_coutD;
   logic             w_cMsb;
   logic [WIDTH-1:0] w_sumNext;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d    (r_a[DIGIT-1:0]),
      .b_d    (r_b[DIGIT-1:0]),
      .cin    (r_carry),
      .s_d    (w_sd),
      .cout_d (w_coutD),
      .c_msb  (w_cMsb)
   );

   // Each new digit enters at the MSB end so after NDIG shifts the LSB digit sits at bit 0.
   if (DIGIT == WIDTH) begin : g_one_digit
      assign w_sumNext = w_sd;
   end else begin : g_multi_digit
      assign w_sumNext = {w_sd, r_sum[WIDTH-1:DIGIT]};
   end

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = r_outValid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_sum      <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b ^ {WIDTH{mode == MODE_SUB}};
                  r_carry <= (mode == MODE_SUB);
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_sum   <= w_sumNext;
               r_carry <= w_coutD;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_cout     <= w_coutD;
                  r_ovf      <= w_cMsb ^ w_coutD;
                  r_zero     <= (w_sumNext == '0);
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: a DIGIT=2 instance and a DIGIT=8 instance
// share operands; each has its own in_valid so they are exercised one at a time.
module tb_addsub_serial;

   logic       clk;
   logic       rst;
   logic       inValid1, inValid2;
   logic [7:0] a, b;
   logic       mode;
   logic       outReady;

   logic       inReady1, outValid1, cout1, ovf1, zero1;
   logic [7:0] sum1;
   logic       inReady2, outValid2, cout2, ovf2, zero2;
   logic [7:0] sum2;

   int sel;
   int testsRun;
   int testsFailed;

   logic       obsInReady, obsOutValid, obsCout, obsOvf, obsZero;
   logic [7:0] obsSum;

   assign obsInReady  = (sel == 2) ? inReady2  : inReady1;
   assign obsOutValid = (sel == 2) ? outValid2 : outValid1;
   assign obsCout     = (sel == 2) ? cout2     : cout1;
   assign obsOvf      = (sel == 2) ? ovf2      : ovf1;
   assign obsZero     = (sel == 2) ? zero2     : zero1;
   assign obsSum      = (sel == 2) ? sum2      : sum1;

   addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
      .a(a), .b(b), .mode(mode), .out_valid(outValid1), .out_ready(outReady),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
   );

   addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
      .a(a), .b(b), .mode(mode), .out_valid(outValid2), .out_ready(outReady),
      .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One full transaction; operands are scrambled right after accept to prove they are not re-sampled.
   task automatic applyStimulus(input string name, input int which,
                                input logic [7:0] aVal, input logic [7:0] bVal, input logic modeVal,
                                input logic [7:0] expSum, input logic expCout, input logic expOvf,
                                input logic expZero, input int expLat, input int hold);
      int lat;
      sel      = which;
      a        = aVal;
      b        = bVal;
      mode     = modeVal;
      outReady = (hold == 0);
      checkOutput($sformatf("%s in_ready idle", name), obsInReady, 1);
      if (which == 2) inValid2 = 1'b1;
      else            inValid1 = 1'b1;
      @(posedge clk); #1;
      inValid1 = 1'b0;
      inValid2 = 1'b0;
      a        = ~aVal;
      b        = 8'h5A;
      mode     = ~modeVal;
      lat      = 0;
      while (!obsOutValid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput($sformatf("%s latency", name), lat, expLat);
      checkOutput($sformatf("%s sum", name), obsSum, expSum);
      checkOutput($sformatf("%s cout", name), obsCout, expCout);
      checkOutput($sformatf("%s ovf", name), obsOvf, expOvf);
      checkOutput($sformatf("%s zero", name), obsZero, expZero);
      checkOutput($sformatf("%s in_ready done", name), obsInReady, 0);
      repeat (hold) begin
         @(posedge clk); #1;
         checkOutput($sformatf("%s hold out_valid", name), obsOutValid, 1);
         checkOutput($sformatf("%s hold sum", name), obsSum, expSum);
         checkOutput($sformatf("%s hold in_ready", name), obsInReady, 0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("%s out_valid released", name), obsOutValid, 0);
      checkOutput($sformatf("%s in_ready released", name), obsInReady, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] aR, bR, bb, sR;
      logic       mR, cR, oR;
      testsRun    = 0;
      testsFailed = 0;
      sel         = 1;
      rst         = 1'b1;
      inValid1    = 1'b0;
      inValid2    = 1'b0;
      a           = '0;
      b           = '0;
      mode        = 1'b0;
      outReady    = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", inReady1, 0);
      checkOutput("reset out_valid", outValid1, 0);
      checkOutput("reset sum", sum1, 0);
      checkOutput("reset flags", {cout1, ovf1, zero1}, 0);
      checkOutput("reset in_ready d8", inReady2, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus("add 05+03", 1, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4, 0);
      applyStimulus("sub 05-03", 1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 4, 0);
      applyStimulus("sub 00-01", 1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4, 0);
      applyStimulus("add 7F+01", 1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 4, 0);
      applyStimulus("sub 80-01", 1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 4, 0);
      applyStimulus("sub 80-80", 1, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 4, 0);
      applyStimulus("add FF+01", 1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4, 0);
      applyStimulus("backpressure", 1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 4, 5);

      // Abort: reset lands on the second RUN cycle.
      sel      = 1;
      a        = 8'h11;
      b        = 8'h22;
      mode     = 1'b0;
      inValid1 = 1'b1;
      @(posedge clk); #1;
      inValid1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("abort in_ready during rst", inReady1, 0);
      @(posedge clk); #1;
      checkOutput("abort out_valid in rst", outValid1, 0);
      checkOutput("abort sum in rst", sum1, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort out_valid after rst", outValid1, 0);
      checkOutput("abort in_ready after rst", inReady1, 1);
      applyStimulus("post-abort 21+13", 1, 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 4, 0);

      applyStimulus("d8 add 7F+01", 2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1, 0);
      applyStimulus("d8 sub 00-01", 2, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         aR = 8'($urandom_range(0, 255));
         bR = 8'($urandom_range(0, 255));
         mR = 1'($urandom_range(0, 1));
         bb = mR ? ~bR : bR;
         {cR, sR} = {1'b0, aR} + {1'b0, bb} + {8'd0, mR};
         oR = (aR[7] == bb[7]) && (sR[7] != aR[7]);
         applyStimulus($sformatf("d8 rand%0d", i), 2, aR, bR, mR, sR, cR, oR, (sR == 8'h00), 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
